market_data_bram_writer: RTL and testbench

MARKET_DATA_BRAM_WRITER -- requirements
Module: market_data_bram_writer

---
 rtl/market_data_bram_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_market_data_bram_writer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/market_data_bram_writer.sv
// market_data_bram_writer
//
// Collects a stream of market-data words into rows of N_COLS words
// (timestamp, open, high, low, close, volume), validates each row's
// framing and timestamp ordering, and writes every good row into an
// external BRAM one word per cycle.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous active-low reset
//   s_valid     stream word valid
//   s_ready     block accepts a word this cycle
//   s_data      stream word (col 0 unsigned timestamp, cols 1-5 float32)
//   s_last      word ends a row
//   clear       synchronous restart of the table (wins over everything)
//   wr_en       BRAM write enable
//   wr_row      BRAM row address (row_count of the row being written)
//   wr_col      BRAM column address, 0..N_COLS-1 ascending
//   wr_data     BRAM write data
//   row_count   number of committed rows
//   full        row_count == N_ROWS
//   err_frame   one-cycle pulse: row discarded for bad framing
//   err_order   one-cycle pulse: row discarded for timestamp going backwards
//   drop_count  rows discarded since reset/clear, saturating at 0xFFFF
//
// The port widths are sized for the default geometry (1024 rows of at most
// 8 columns); N_ROWS must not exceed 1024 and N_COLS must not exceed 8.

module market_data_bram_writer #(
    parameter int N_ROWS = 1024,
    parameter int N_COLS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        clear,
    output logic        wr_en,
    output logic [9:0]  wr_row,
    output logic [2:0]  wr_col,
    output logic [31:0] wr_data,
    output logic [10:0] row_count,
    output logic        full,
    output logic        err_frame,
    output logic        err_order,
    output logic [15:0] drop_count
);

    localparam logic [2:0]  LAST_COL  = 3'(N_COLS - 1);
    localparam logic [10:0] ROW_LIMIT = 11'(N_ROWS);

    typedef enum logic [1:0] {
        COLLECT,
        COMMIT,
        FULL
    } state_t;

    state_t      state;
    state_t      state_next;

    // Goes high on the first edge after reset is released, so s_ready stays
    // low for the whole reset period and the edge that follows it.
    logic        running;

    logic [2:0]  col;          // next buffer slot to fill
    logic [2:0]  wcol;         // column being written during COMMIT
    logic [31:0] row_buf [N_COLS];
    logic [31:0] last_ts;      // timestamp of the most recent committed row
    logic        has_prev;     // at least one row committed since reset/clear

    // Decoded events for this cycle
    logic        take;         // word accepted and not overridden by clear
    logic        frame_bad;
    logic        row_end;      // correctly framed end of row
    logic        order_bad;
    logic        commit_go;
    logic        commit_done;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven from always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        take        = 1'b0;
        frame_bad   = 1'b0;
        row_end     = 1'b0;
        order_bad   = 1'b0;
        commit_go   = 1'b0;
        commit_done = 1'b0;

        // A word arriving together with clear is simply dropped.
        take = s_valid && s_ready && !clear;

        if (take) begin
            // s_last must coincide exactly with the final column.
            frame_bad = (s_last != (col == LAST_COL));
            row_end   = s_last && (col == LAST_COL);
        end

        // row_buf[0] was captured on an earlier word of this row.
        order_bad = row_end && has_prev && (row_buf[0] < last_ts);
        commit_go = row_end && !order_bad;

        commit_done = (state == COMMIT) && !clear && (wcol == LAST_COL);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the values from before this edge.
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        wr_en      = 1'b0;

        case (state)
            COLLECT: begin
                s_ready = running;
                if (commit_go) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                // clear abandons the row immediately, including this cycle's write.
                wr_en = !clear;
                if (commit_done) begin
                    state_next = (row_count + 11'd1 == ROW_LIMIT) ? FULL : COLLECT;
                end
            end
            FULL: begin
                state_next = FULL;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase

        if (clear) begin
            state_next = COLLECT;
        end
    end

    // ------------------------------------------------------------------
    // Control counters, ordering state and error pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running    <= 1'b0;
            col        <= '0;
            wcol       <= '0;
            row_count  <= '0;
            drop_count <= '0;
            last_ts    <= '0;
            has_prev   <= 1'b0;
            err_frame  <= 1'b0;
            err_order  <= 1'b0;
        end else begin
            running <= 1'b1;

            if (clear) begin
                col        <= '0;
                wcol       <= '0;
                row_count  <= '0;
                drop_count <= '0;
                has_prev   <= 1'b0;
                err_frame  <= 1'b0;
                err_order  <= 1'b0;
            end else begin
                err_frame <= frame_bad;
                err_order <= order_bad;

                if (take) begin
                    if (frame_bad || row_end) begin
                        col <= '0;
                    end else begin
                        col <= col + 3'd1;
                    end
                end

                if ((frame_bad || order_bad) && (drop_count != 16'hFFFF)) begin
                    drop_count <= drop_count + 16'd1;
                end

                if (state == COMMIT) begin
                    if (commit_done) begin
                        wcol      <= '0;
                        row_count <= row_count + 11'd1;
                        last_ts   <= row_buf[0];
                        has_prev  <= 1'b1;
                    end else begin
                        wcol <= wcol + 3'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Row buffer
    // ------------------------------------------------------------------
    // NOTE: the row buffer has no reset; every slot is written before it is
    // read for a commit, so its power-up contents never reach the BRAM.
    always_ff @(posedge clk) begin
        if (take) begin
            row_buf[col] <= s_data;
        end
    end

    // ------------------------------------------------------------------
    // BRAM write port and status
    // ------------------------------------------------------------------
    assign wr_row  = row_count[9:0];
    assign wr_col  = wcol;
    assign wr_data = row_buf[wcol];
    assign full    = (row_count == ROW_LIMIT);

endmodule

// File: tb/tb_market_data_bram_writer.sv
// Self-checking bench for market_data_bram_writer.
// A row-level reference model decides, from the framing and timestamp rules,
// whether each row is committed or dropped, tracks the expected counters and
// keeps the expected BRAM image; a monitor keeps a shadow of every BRAM write.

module tb_market_data_bram_writer;

    typedef logic [31:0] row_t [6];

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        clear;
    logic        wr_en;
    logic [9:0]  wr_row;
    logic [2:0]  wr_col;
    logic [31:0] wr_data;
    logic [10:0] row_count;
    logic        full;
    logic        err_frame;
    logic        err_order;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int unsigned m_rows;
    int unsigned m_drops;
    logic [31:0] m_last_ts;
    bit          m_has_prev;
    logic [31:0] exp_mem [1024][6];
    logic [31:0] shadow  [1024][6];

    market_data_bram_writer #(
        .N_ROWS(1024),
        .N_COLS(6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .row_count  (row_count),
        .full       (full),
        .err_frame  (err_frame),
        .err_order  (err_order),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Shadow BRAM: record every write seen on the write port.
    always @(negedge clk) begin
        if (reset === 1'b1 && wr_en === 1'b1 && wr_col < 3'd6) begin
            shadow[wr_row][wr_col] = wr_data;
        end
    end

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_rows     = 0;
        m_drops    = 0;
        m_has_prev = 1'b0;
    endtask

    // Offer one word and hold it until it is accepted (bounded wait).
    task automatic send_word(input logic [31:0] d, input bit last);
        int budget;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        budget  = 0;
        while (s_ready !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (s_ready !== 1'b1) begin
            check("accept_timeout", s_ready, 1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Send the first len words of w (s_last on the final one), then check the
    // outcome the row-level rules predict.
    task automatic send_row(input row_t w, input int len, input bit gaps);
        bit exp_frame;
        bit exp_order;
        int unsigned row;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            send_word(w[i], (i == len - 1));
        end

        exp_frame = (len != 6);
        exp_order = !exp_frame && m_has_prev && (w[0] < m_last_ts);

        if (exp_frame || exp_order) begin
            if (m_drops < 32'hFFFF) m_drops++;
            @(negedge clk);
            check("err_frame", err_frame, exp_frame);
            check("err_order", err_order, exp_order);
            check("drop_wr_en", wr_en, 0);
            check("drop_count", drop_count, m_drops);
            check("drop_row_count", row_count, m_rows);
            @(negedge clk);
            check("err_pulse_end", {err_frame, err_order}, 0);
            check("drop_s_ready", s_ready, 1);
        end else begin
            row = m_rows;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                check("wr_en", wr_en, 1);
                check("wr_row", wr_row, row);
                check("wr_col", wr_col, c);
                check("wr_data", wr_data, w[c]);
                if (c == 0) begin
                    check("commit_no_err", {err_frame, err_order}, 0);
                    check("commit_s_ready", s_ready, 0);
                end
                exp_mem[row][c] = w[c];
            end
            m_rows++;
            m_last_ts  = w[0];
            m_has_prev = 1'b1;
            @(negedge clk);
            check("wr_en_after", wr_en, 0);
            check("row_count", row_count, m_rows);
            check("full", full, (m_rows == 1024));
            check("s_ready_after", s_ready, (m_rows != 1024));
        end
    endtask

    // One-cycle clear, optionally with a word offered in the same cycle.
    task automatic do_clear(input bit with_word);
        @(negedge clk);
        clear = 1'b1;
        if (with_word) begin
            s_valid = 1'b1;
            s_data  = 32'hDEAD_BEEF;
            s_last  = 1'b0;
        end
        @(posedge clk);
        #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        model_clear();
        @(negedge clk);
        check("clear_row_count", row_count, 0);
        check("clear_drop_count", drop_count, 0);
        check("clear_full", full, 0);
        check("clear_s_ready", s_ready, 1);
    endtask

    task automatic readback();
        for (int r = 0; r < int'(m_rows); r++) begin
            for (int c = 0; c < 6; c++) begin
                check("readback", shadow[r][c], exp_mem[r][c]);
            end
        end
    endtask

    initial begin
        row_t w;
        int   valid;
        int   iter;
        int unsigned prev;
        int   kind;
        int   len;

        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        clear   = 1'b0;
        model_clear();
        m_last_ts = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_full", full, 0);
        check("rst_row_count", row_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_err", {err_frame, err_order}, 0);
        reset = 1'b1;
        #1;
        check("rel_s_ready_before_edge", s_ready, 0);
        @(negedge clk);
        check("rel_s_ready_after_edge", s_ready, 1);

        // Basic row: ts=100, 1.0 .. 5.0
        w = '{32'd100, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
              32'h4080_0000, 32'h40A0_0000};
        send_row(w, 6, 0);

        // Framing error: s_last on the 3rd word, then a good row from col 0
        w = '{32'd110, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        send_row(w, 3, 0);
        w = '{32'd120, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
        send_row(w, 6, 0);

        // Clear with a word offered in the same cycle; the word must be lost
        do_clear(1'b1);

        // Ordering: 200 ok, 150 rejected, 200 (equal) ok
        w = '{32'd200, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25};
        send_row(w, 6, 0);
        w = '{32'd150, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35};
        send_row(w, 6, 0);
        check("order_row_count", row_count, 1);
        w = '{32'd200, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45};
        send_row(w, 6, 0);

        // Clear during the wr_col=3 commit cycle
        w = '{32'd300, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
        for (int i = 0; i < 6; i++) send_word(w[i], (i == 5));
        repeat (4) @(negedge clk);
        check("pre_clear_wr_col", wr_col, 3);
        check("pre_clear_wr_en", wr_en, 1);
        clear = 1'b1;
        #1;
        check("clear_kills_wr_en", wr_en, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_clear();
        @(negedge clk);
        check("mid_clear_row_count", row_count, 0);
        check("mid_clear_wr_en", wr_en, 0);
        check("mid_clear_s_ready", s_ready, 1);
        w = '{32'd10, 32'h61, 32'h62, 32'h63, 32'h64, 32'h65};
        send_row(w, 6, 0);

        // Random rows with s_valid gaps, bad rows mixed in, until 20 commit
        valid = 0;
        iter  = 0;
        while (valid < 20 && iter < 200) begin
            iter++;
            for (int c = 0; c < 6; c++) w[c] = $urandom();
            kind = $urandom_range(0, 9);
            len  = 6;
            if (kind == 0) begin
                len  = $urandom_range(1, 5);
                w[0] = m_last_ts + 32'd1;
            end else if (kind == 1 && m_has_prev && m_last_ts > 0) begin
                w[0] = m_last_ts - 32'd1 - ($urandom % m_last_ts);
            end else begin
                w[0] = m_last_ts + $urandom_range(0, 50);
            end
            prev = m_rows;
            send_row(w, len, 1);
            if (m_rows > prev) valid++;
        end
        check("random_rows_committed", row_count, 21);
        readback();

        // Fill the whole table
        do_clear(1'b0);
        for (int i = 0; i < 1024; i++) begin
            for (int c = 1; c < 6; c++) w[c] = $urandom();
            w[0] = i;
            send_row(w, 6, 0);
        end
        check("fill_full", full, 1);
        check("fill_row_count", row_count, 1024);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'd5000;
        s_last  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("full_s_ready", s_ready, 0);
            check("full_wr_en", wr_en, 0);
        end
        s_valid = 1'b0;
        check("full_hold_count", row_count, 1024);
        readback();
        do_clear(1'b0);

        // Reset asserted mid-commit drops wr_en at once
        w = '{32'd7, 32'h71, 32'h72, 32'h73, 32'h74, 32'h75};
        for (int i = 0; i < 6; i++) send_word(w[i], (i == 5));
        @(negedge clk);
        check("pre_reset_wr_en", wr_en, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_wr_en", wr_en, 0);
        check("async_reset_s_ready", s_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        m_last_ts = '0;
        @(negedge clk);
        check("post_reset_s_ready", s_ready, 1);
        check("post_reset_row_count", row_count, 0);
        w = '{32'd1, 32'h81, 32'h82, 32'h83, 32'h84, 32'h85};
        send_row(w, 6, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
